// File: rtl/pc_ras_unit.sv
// pc_ras_unit: fetch program counter with a circular return-address stack
module pc_ras_unit #(
  parameter int               WIDTH        = 32,
  parameter int               INC          = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [2:0]       pcMode,
  input  logic [WIDTH-1:0] pcIn,
  input  logic [WIDTH-1:0] literal,
  input  logic             clrFlags,
  output logic [WIDTH-1:0] pcOutput,
  output logic [WIDTH-1:0] pcSeq,
  output logic             rasEmpty,
  output logic             rasFull,
  output logic             rasOverflow,
  output logic             rasUnderflow
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(RAS_DEPTH);
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PW-1:0]    ptr_q, ptr_d, top;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d, udf_q, udf_d;
  logic [WIDTH-1:0] stack_q [RAS_DEPTH];
  logic             push, pop;
  assign pcOutput     = pc_q;
  assign pcSeq        = pc_q + WIDTH'(INC);
  assign rasEmpty     = cnt_q == '0;
  assign rasFull      = cnt_q == FULL;
  assign rasOverflow  = ovf_q;
  assign rasUnderflow = udf_q;
  assign top          = ptr_q - PW'(1);
  // next-state selection: ptr_q is the next free slot, so the newest entry sits at ptr_q-1
  always_comb begin
    push  = enable && (pcMode == 3'd3 || pcMode == 3'd4);
    pop   = enable && pcMode == 3'd5;
    pc_d  = !enable ? pc_q :
            (pcMode == 3'd1 || pcMode == 3'd3) ? pc_q + literal :
            (pcMode == 3'd2 || pcMode == 3'd4) ? pcIn :
            pop ? (rasEmpty ? pcIn : stack_q[top]) : pcSeq;
    ptr_d = push ? ptr_q + PW'(1) : (pop && !rasEmpty) ? top : ptr_q;
    cnt_d = push ? (rasFull ? cnt_q : cnt_q + CW'(1)) :
            (pop && !rasEmpty) ? cnt_q - CW'(1) : cnt_q;
    ovf_d = (push && rasFull) || (ovf_q && !clrFlags);
    udf_d = (pop && rasEmpty) || (udf_q && !clrFlags);
  end
  // PC, pointer, count and sticky flags with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q  <= RESET_VECTOR;
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end
  // stack entries need no reset; when full the slot at ptr_q holds the oldest link
  always_ff @(posedge clk) begin
    if (push) stack_q[ptr_q] <= pcSeq;
  end
endmodule
